// File: rtl/shifter_pkg.sv
// Shared opcode definitions for the pipelined barrel shifter.
package shifter_pkg;

    // Opcode encoding seen on in_op; codes from OP_RESERVED upward are pass-through.
    typedef enum logic [2:0] {
        SLL = 3'b000,
        SRL = 3'b001,
        SRA = 3'b010,
        ROL = 3'b011,
        ROR = 3'b100
    } shift_op_t;

    // Lowest reserved opcode: data passes through untouched with carry 0.
    localparam logic [2:0] OP_RESERVED = 3'b101;

endpackage

// File: rtl/shift_stage.sv
// One pipeline stage: optional shift/rotate by a fixed DISTANCE, carry tracking,
// and the valid/data/carry register that follows it.
module shift_stage
    import shifter_pkg::*;
#(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned DISTANCE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic             valid_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             carry_i,
    input  logic [2:0]       op_i,
    input  logic             sel_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o,
    output logic             carry_o
);

    logic             valid_q;
    logic [WIDTH-1:0] data_q,  data_d;
    logic             carry_q, carry_d;

    // Shift by DISTANCE when this stage's amount bit is set. Carry is only
    // rewritten by an active stage, so after the last stage it holds the
    // final bit shifted out (or the rotate result bit), and 0 for amt=0.
    always_comb begin
        data_d  = data_i;
        carry_d = carry_i;
        if (sel_i && (op_i < OP_RESERVED)) begin
            case (op_i)
                SLL: begin
                    data_d  = data_i << DISTANCE;
                    carry_d = data_i[WIDTH-DISTANCE];
                end
                SRL: begin
                    data_d  = data_i >> DISTANCE;
                    carry_d = data_i[DISTANCE-1];
                end
                SRA: begin
                    data_d  = {{DISTANCE{data_i[WIDTH-1]}}, data_i[WIDTH-1:DISTANCE]};
                    carry_d = data_i[DISTANCE-1];
                end
                ROL: begin
                    data_d  = {data_i[WIDTH-1-DISTANCE:0], data_i[WIDTH-1:WIDTH-DISTANCE]};
                    carry_d = data_i[WIDTH-DISTANCE];
                end
                ROR: begin
                    data_d  = {data_i[DISTANCE-1:0], data_i[WIDTH-1:DISTANCE]};
                    carry_d = data_i[DISTANCE-1];
                end
                default: begin
                    data_d  = data_i;
                    carry_d = carry_i;
                end
            endcase
        end
    end

    // Stage register; holds whenever the pipeline is stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            carry_q <= 1'b0;
        end else if (en_i) begin
            valid_q <= valid_i;
            data_q  <= data_d;
            carry_q <= carry_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign carry_o = carry_q;

endmodule

// File: rtl/pipelined_shifter.sv
// LOG2W-stage pipelined barrel shifter/rotator with valid/ready handshake.
// Stage k shifts by 2^(LOG2W-1-k); the whole pipeline advances in lock-step.
module pipelined_shifter
    import shifter_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned LOG2W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [LOG2W-1:0] in_amt,
    input  logic [2:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_carry,
    output logic             out_zero
);

    if ((WIDTH < 4) || ((WIDTH & (WIDTH - 1)) != 0)) begin : g_bad_width
        $error("pipelined_shifter: WIDTH must be a power of two >= 4");
    end

    logic             v_s [LOG2W];
    logic [WIDTH-1:0] d_s [LOG2W];
    logic             c_s [LOG2W];

    for (genvar k = 0; k < LOG2W; k++) begin : g_stage
        // Amount bits still to be consumed: this stage uses the MSB.
        localparam int unsigned AW = LOG2W - k;

        logic [AW-1:0]    amt_in;
        logic [2:0]       op_in;
        logic             v_in;
        logic [WIDTH-1:0] d_in;
        logic             c_in;

        if (k == 0) begin : g_first
            assign amt_in = in_amt;
            assign op_in  = in_op;
            assign v_in   = in_valid;
            assign d_in   = in_data;
            assign c_in   = 1'b0;
        end else begin : g_next
            assign amt_in = g_stage[k-1].g_ctrl.amt_q;
            assign op_in  = g_stage[k-1].g_ctrl.op_q;
            assign v_in   = v_s[k-1];
            assign d_in   = d_s[k-1];
            assign c_in   = c_s[k-1];
        end

        shift_stage #(
            .WIDTH    (WIDTH),
            .DISTANCE (1 << (AW - 1))
        ) u_stage (
            .clk     (clk),
            .rst     (rst),
            .en_i    (in_ready),
            .valid_i (v_in),
            .data_i  (d_in),
            .carry_i (c_in),
            .op_i    (op_in),
            .sel_i   (amt_in[AW-1]),
            .valid_o (v_s[k]),
            .data_o  (d_s[k]),
            .carry_o (c_s[k])
        );

        // Control travelling with the data; only the not-yet-used amount
        // bits are kept, and the last stage needs none.
        if (k < LOG2W - 1) begin : g_ctrl
            logic [AW-2:0] amt_q;
            logic [2:0]    op_q;

            // Control register for the next stage, stalled with the data.
            always_ff @(posedge clk) begin
                if (rst) begin
                    amt_q <= '0;
                    op_q  <= '0;
                end else if (in_ready) begin
                    amt_q <= amt_in[AW-2:0];
                    op_q  <= op_in;
                end
            end
        end
    end

    assign out_valid = v_s[LOG2W-1];
    assign out_data  = d_s[LOG2W-1];
    assign out_carry = c_s[LOG2W-1];
    // Gated by valid so the flag reads 0 after reset and on bubbles.
    assign out_zero  = v_s[LOG2W-1] && (d_s[LOG2W-1] == '0);
    assign in_ready  = out_ready || !out_valid;

endmodule

// File: tb/tb_pipelined_shifter.sv
// Bench for pipelined_shifter (WIDTH=16): directed vector table, back-pressure,
// reset-in-flight and a random regression against an iterative reference model.
module tb_pipelined_shifter;

    localparam int unsigned W  = 16;
    localparam int unsigned LW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid, in_ready;
    logic [W-1:0]  in_data;
    logic [LW-1:0] in_amt;
    logic [2:0]    in_op;
    logic          out_valid, out_ready;
    logic [W-1:0]  out_data;
    logic          out_carry, out_zero;

    always #5 clk = ~clk;

    pipelined_shifter #(.WIDTH(W), .LOG2W(LW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_amt    (in_amt),
        .in_op     (in_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_carry (out_carry),
        .out_zero  (out_zero)
    );

    typedef struct {
        logic [2:0]    op;
        logic [LW-1:0] amt;
        logic [W-1:0]  data;
        logic [W-1:0]  xd;
        logic          xc;
        logic          xz;
        bit            lat;
    } vec_t;

    typedef struct {
        logic [W-1:0] xd;
        logic         xc;
        logic         xz;
        bit           lat;
        int           acc;
    } exp_t;

    vec_t stim[$];
    exp_t expq[$];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    bit           stall_prev = 1'b0;
    logic [W-1:0] prev_d;
    logic         prev_c, prev_z;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: one bit position per step, independent of the staged structure.
    function automatic vec_t model(input logic [2:0] op, input logic [LW-1:0] amt, input logic [W-1:0] data);
        vec_t v;
        logic [W-1:0] r;
        logic c;
        r = data;
        c = 1'b0;
        for (int unsigned i = 0; i < amt; i++) begin
            case (op)
                3'd0: begin c = r[W-1]; r = r << 1; end
                3'd1: begin c = r[0];   r = r >> 1; end
                3'd2: begin c = r[0];   r = {r[W-1], r[W-1:1]}; end
                3'd3: r = {r[W-2:0], r[W-1]};
                3'd4: r = {r[0], r[W-1:1]};
                default: ;
            endcase
        end
        if (op == 3'd3) c = (amt != 0) ? r[0] : 1'b0;
        if (op == 3'd4) c = (amt != 0) ? r[W-1] : 1'b0;
        v.op = op; v.amt = amt; v.data = data;
        v.xd = r; v.xc = c; v.xz = (r == '0); v.lat = 1'b0;
        return v;
    endfunction

    // One clock cycle: drive at negedge, check/record handshakes before the posedge.
    task automatic cycle(input logic rdy, input bit allow_in);
        exp_t e;
        @(negedge clk);
        out_ready = rdy;
        if (allow_in && stim.size() > 0) begin
            in_valid = 1'b1;
            in_op    = stim[0].op;
            in_amt   = stim[0].amt;
            in_data  = stim[0].data;
        end else begin
            in_valid = 1'b0;
            in_op    = 3'($urandom);
            in_amt   = LW'($urandom);
            in_data  = W'($urandom);
        end
        #1;
        if (stall_prev) begin
            chk("hold_valid", W'(out_valid), W'(1));
            chk("hold_data",  out_data, prev_d);
            chk("hold_flags", W'({out_carry, out_zero}), W'({prev_c, prev_z}));
        end
        if (out_valid && !out_ready) chk("stall_ready", W'(in_ready), W'(0));
        if (out_valid && out_ready) begin
            if (expq.size() == 0) begin
                chk("spurious_out", W'(out_valid), W'(0));
            end else begin
                e = expq.pop_front();
                chk("data",  out_data,      e.xd);
                chk("carry", W'(out_carry), W'(e.xc));
                chk("zero",  W'(out_zero),  W'(e.xz));
                if (e.lat) chk("latency", W'(cyc - e.acc), W'(LW));
            end
        end
        if (in_valid && in_ready) begin
            e.xd = stim[0].xd; e.xc = stim[0].xc; e.xz = stim[0].xz;
            e.lat = stim[0].lat; e.acc = cyc;
            expq.push_back(e);
            void'(stim.pop_front());
        end
        stall_prev = out_valid && !out_ready;
        prev_d = out_data; prev_c = out_carry; prev_z = out_zero;
        cyc++;
    endtask

    task automatic drain(input string name, input int budget, input bit rnd);
        int n;
        n = 0;
        while ((stim.size() > 0 || expq.size() > 0) && n < budget) begin
            cycle(rnd ? ($urandom_range(0, 3) != 0) : 1'b1, rnd ? ($urandom_range(0, 4) != 0) : 1'b1);
            n++;
        end
        chk(name, W'(stim.size() + expq.size()), W'(0));
    endtask

    vec_t tbl[20];
    vec_t v;

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in_data = '0; in_amt = '0; in_op = '0;

        // Directed vectors with hand-computed results.
        tbl[0]  = '{3'd0, 4'd1,  16'h8001, 16'h0002, 1'b1, 1'b0, 1'b1};
        tbl[1]  = '{3'd2, 4'd15, 16'h8000, 16'hFFFF, 1'b0, 1'b0, 1'b1};
        tbl[2]  = '{3'd1, 4'd15, 16'h8000, 16'h0001, 1'b0, 1'b0, 1'b1};
        tbl[3]  = '{3'd1, 4'd1,  16'h0001, 16'h0000, 1'b1, 1'b1, 1'b1};
        tbl[4]  = '{3'd4, 4'd4,  16'h1234, 16'h4123, 1'b0, 1'b0, 1'b1};
        tbl[5]  = '{3'd3, 4'd1,  16'h8001, 16'h0003, 1'b1, 1'b0, 1'b1};
        for (int unsigned i = 0; i < 8; i++)
            tbl[6+i] = '{3'(i), 4'd0, 16'hBEEF, 16'hBEEF, 1'b0, 1'b0, 1'b1};
        tbl[14] = '{3'd5, 4'd5,  16'h1234, 16'h1234, 1'b0, 1'b0, 1'b1};
        tbl[15] = '{3'd7, 4'd15, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b1};
        tbl[16] = '{3'd0, 4'd15, 16'h0001, 16'h8000, 1'b0, 1'b0, 1'b1};
        tbl[17] = '{3'd2, 4'd15, 16'h7FFF, 16'h0000, 1'b1, 1'b1, 1'b1};
        tbl[18] = '{3'd0, 4'd4,  16'hFFFF, 16'hFFF0, 1'b1, 1'b0, 1'b1};
        tbl[19] = '{3'd3, 4'd4,  16'h1234, 16'h2341, 1'b1, 1'b0, 1'b1};

        // Reset state.
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_out_valid", W'(out_valid), W'(0));
        chk("rst_out_data",  out_data,      W'(0));
        chk("rst_out_carry", W'(out_carry), W'(0));
        chk("rst_out_zero",  W'(out_zero),  W'(0));
        chk("rst_in_ready",  W'(in_ready),  W'(1));

        // Directed table, back-to-back with the consumer always ready.
        foreach (tbl[i]) stim.push_back(tbl[i]);
        drain("table_drain", 60, 1'b0);

        // Back-pressure: 6 ops, out_ready low for 5 cycles once results arrive.
        for (int unsigned i = 0; i < 6; i++) stim.push_back(model(3'(i % 5), 4'(i + 1), 16'h0F0F + 16'(i * 16'h1111)));
        for (int i = 0; i < 10; i++) cycle(!(i >= 4 && i < 9), 1'b1);
        chk("bp_no_loss_yet", W'(expq.size() + stim.size() > 0), W'(1));
        drain("bp_drain", 40, 1'b0);

        // Reset with 3 operations in flight.
        for (int unsigned i = 0; i < 3; i++) stim.push_back(model(3'd0, 4'd2, 16'h0101 << i));
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1);
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
        stall_prev = 1'b0;
        expq.delete();
        stim.delete();
        #1;
        chk("midrst_in_ready",  W'(in_ready),  W'(1));
        chk("midrst_out_valid", W'(out_valid), W'(0));
        for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0);
        v = model(3'd4, 4'd8, 16'hA55A);
        v.lat = 1'b1;
        stim.push_back(v);
        drain("midrst_drain", 20, 1'b0);

        // Random regression with random back-pressure and bubbles.
        for (int i = 0; i < 10000; i++) begin
            stim.push_back(model(3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), W'($urandom)));
            while (stim.size() > 1) cycle($urandom_range(0, 3) != 0, $urandom_range(0, 4) != 0);
        end
        drain("rand_drain", 200, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/pipelined_shifter.md
PIPELINED_SHIFTER -- requirements
Module: pipelined_shifter

Interface
REQ-001 Parameter WIDTH, default 16: data width; SHALL be a power of two, at least 4.
REQ-002 Parameter LOG2W, default $clog2(WIDTH): shift-amount width and pipeline depth.
REQ-003 Port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1: reset, synchronous and active-high.
REQ-005 Port in_valid, input, 1: in_data, in_amt and in_op are valid.
REQ-006 Port in_ready, output, 1: block can accept an operation this cycle.
REQ-007 Port in_data, input, WIDTH: operand.
REQ-008 Port in_amt, input, LOG2W: shift/rotate amount, 0 to WIDTH-1.
REQ-009 Port in_op, input, 3: operation code (REQ-013).
REQ-010 Port out_valid, output, 1: out_data, out_carry and out_zero are valid.
REQ-011 Port out_ready, input, 1: consumer accepts the result this cycle.
REQ-012 Ports out_data (output, WIDTH), out_carry (output, 1) and out_zero (output, 1): result, last bit shifted out, and result==0.

Function
REQ-013 Opcodes: 000 SLL, 001 SRL, 010 SRA (sign fill from in_data[WIDTH-1]), 011 ROL, 100 ROR; 101-111 reserved.
REQ-014 Reserved opcodes SHALL pass in_data unchanged, with out_carry=0.
REQ-015 Transfers: input on in_valid&&in_ready; output on out_valid&&out_ready.
REQ-016 Pipeline: LOG2W stages; stage k conditionally shifts by 2^(LOG2W-1-k) (MSB of amount first); one register after each stage.
REQ-017 Latency: exactly LOG2W cycles from input transfer to out_valid when not stalled; throughput one operation per cycle.
REQ-018 Stall rule: in_ready = out_ready || !out_valid. While in_ready=0 all stage registers hold.
REQ-019 No operation is dropped, duplicated or reordered under any out_ready pattern.
REQ-020 Outputs SHALL hold stable while out_valid=1 and out_ready=0.
REQ-021 Carry, SLL/SRL/SRA: the last bit shifted out; 0 when amt=0.
REQ-022 Carry, ROL: result bit 0. Carry, ROR: result bit WIDTH-1. Both 0 when amt=0.
REQ-023 SRA by WIDTH-1 SHALL yield all copies of the sign bit.
REQ-024 amt=0 SHALL pass data unchanged for every opcode.
REQ-025 out_zero SHALL be 1 iff out_data==0, evaluated on the registered result.
REQ-026 A valid bit per stage SHALL travel with the data. Bubbles (in_valid=0) propagate as invalid slots and are not compacted.

Reset
REQ-027 With rst=1 at a clock edge, all stage valid bits clear; out_valid=0, out_data=0, out_carry=0, out_zero=0 from the next cycle.
REQ-028 Reset mid-operation discards every in-flight operation; no result is emitted for them.
REQ-029 in_ready SHALL be 1 in the first cycle after reset deasserts.
REQ-030 rst SHALL take priority over in_valid and out_ready in the same cycle.

Structure
REQ-031 Package shifter_pkg SHALL hold the opcode enum (shift_op_t: SLL, SRL, SRA, ROL, ROR) and the reserved-opcode constant.
REQ-032 Sub-module shift_stage SHALL implement one stage: parameterised by WIDTH and DISTANCE; mux, carry update, valid/data register with enable.
REQ-033 The top level instantiates LOG2W shift_stage instances in a generate loop and computes the zero flag at the final stage.

Verification (WIDTH=16)
REQ-034 SLL 0x8001 by 1 -> out_data 0x0002, carry 1, zero 0, exactly 4 cycles after acceptance.
REQ-035 SRA 0x8000 by 15 -> 0xFFFF, carry 0. SRL 0x8000 by 15 -> 0x0001, carry 0. SRL 0x0001 by 1 -> 0x0000, carry 1, zero 1.
REQ-036 ROR 0x1234 by 4 -> 0x4123, carry 0. ROL 0x8001 by 1 -> 0x0003, carry 1. Any op with amt 0 on 0xBEEF -> 0xBEEF, carry 0.
REQ-037 Back-pressure: issue 6 back-to-back ops, hold out_ready=0 for 5 cycles, then release -> 6 results in issue order, none lost. in_ready=0 while stalled, outputs stable.
REQ-038 Reset mid-flight: assert rst for 1 cycle with 3 ops in flight -> no result emitted; next op's result appears 4 cycles after its acceptance.
REQ-039 Random regression of 10k ops with random out_ready, checked against a reference model for all opcodes including reserved ones.
